// File: rtl/counter_bcd_ndigit.sv
// Parametrised N-decade BCD counter: up/down, enable, parallel load with per-digit
// clamping, wrap or saturate at the boundary, combinational Tc and registered Co.
module counter_bcd_ndigit #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  R,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   O,
  output logic                  Tc,
  output logic                  Co
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] clamped;
  logic [W-1:0] stepped;
  logic [3:0]   dig;
  logic [3:0]   ldig;
  logic         carry;
  logic         at_limit;

  // Ripple the step through the decades; carry ends high only when every digit sits at its limit.
  always_comb begin
    clamped = '0;
    stepped = O;
    dig     = 4'd0;
    ldig    = 4'd0;
    carry   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig  = O[4*i +: 4];
      ldig = D[4*i +: 4];
      clamped[4*i +: 4] = (ldig > 4'd9) ? 4'd9 : ldig;
      if (carry) begin
        if (Up) stepped[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else    stepped[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      carry = carry & (Up ? (dig == 4'd9) : (dig == 4'd0));
    end
    at_limit = carry;
  end

  assign Tc = at_limit;

  // Priority: reset, load, count, hold. Co marks a boundary crossing or a blocked attempt.
  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      O  <= '0;
      Co <= 1'b0;
    end else if (Load) begin
      O  <= clamped;
      Co <= 1'b0;
    end else if (En) begin
      if (at_limit) begin
        Co <= 1'b1;
        if (WRAP) O <= stepped;
      end else begin
        O  <= stepped;
        Co <= 1'b0;
      end
    end else begin
      Co <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_bcd_ndigit.sv
// Directed bench for counter_bcd_ndigit: 2-digit wrap, 2-digit saturate and 4-digit
// instances share the control inputs; each step checks the instance under test.
module tb_counter_bcd_ndigit;

  logic        Clk = 1'b0;
  logic        R, En, Up, Load;
  logic [7:0]  d2;
  logic [15:0] d4;
  logic [7:0]  o_w, o_s;
  logic [15:0] o_4;
  logic        tc_w, tc_s, tc_4, co_w, co_s, co_4;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  counter_bcd_ndigit #(.DIGITS(2), .WRAP(1'b1)) u_w (
    .Clk(Clk), .R(R), .En(En), .Up(Up), .Load(Load), .D(d2), .O(o_w), .Tc(tc_w), .Co(co_w));
  counter_bcd_ndigit #(.DIGITS(2), .WRAP(1'b0)) u_s (
    .Clk(Clk), .R(R), .En(En), .Up(Up), .Load(Load), .D(d2), .O(o_s), .Tc(tc_s), .Co(co_s));
  counter_bcd_ndigit #(.DIGITS(4), .WRAP(1'b1)) u_4 (
    .Clk(Clk), .R(R), .En(En), .Up(Up), .Load(Load), .D(d4), .O(o_4), .Tc(tc_4), .Co(co_4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    logic [7:0] bcd;
    R = 1'b1; En = 1'b0; Up = 1'b0; Load = 1'b0; d2 = 8'h00; d4 = 16'h0000;

    // reset state, asserted before any clock edge
    #3;
    check("rst_o_w", 32'(o_w), 32'h00);
    check("rst_co_w", 32'(co_w), 32'd0);
    check("rst_o_4", 32'(o_4), 32'h0000);
    check("rst_tc_down_zero", 32'(tc_w), 32'd1);
    R = 1'b0;

    // count up 100 edges: 01..99, 00
    En = 1'b1; Up = 1'b1;
    #1;
    check("tc_up_at_00", 32'(tc_w), 32'd0);
    for (int k = 0; k < 100; k++) begin
      step();
      v = (k + 1) % 100;
      bcd = {4'(v / 10), 4'(v % 10)};
      check("up_o", 32'(o_w), 32'(bcd));
      check("up_co", 32'(co_w), (k == 99) ? 32'd1 : 32'd0);
      check("up_tc", 32'(tc_w), (v == 99) ? 32'd1 : 32'd0);
    end
    check("up100_o_4", 32'(o_4), 32'h0100);
    for (int k = 0; k < 5; k++) step();
    check("pre_pulse_o", 32'(o_w), 32'h05);
    #2 R = 1'b1;
    #1;
    check("pulse_o_async", 32'(o_w), 32'h00);
    check("pulse_co_async", 32'(co_w), 32'd0);
    R = 1'b0;

    // load priority with per-digit clamping
    Load = 1'b1; En = 1'b1; Up = 1'b1; d2 = 8'hA7; d4 = 16'hFAB3;
    step();
    check("load_clamp_o", 32'(o_w), 32'h97);
    check("load_clamp_co", 32'(co_w), 32'd0);
    check("load_clamp_o_4", 32'(o_4), 32'h9993);
    Load = 1'b0;
    step();
    check("after_load_up", 32'(o_w), 32'h98);

    // down wrap
    Load = 1'b1; d2 = 8'h01; Up = 1'b0;
    step();
    check("dn_load", 32'(o_w), 32'h01);
    check("dn_tc_01", 32'(tc_w), 32'd0);
    Load = 1'b0;
    step();
    check("dn_00", 32'(o_w), 32'h00);
    check("dn_00_tc", 32'(tc_w), 32'd1);
    check("dn_00_co", 32'(co_w), 32'd0);
    step();
    check("dn_99", 32'(o_w), 32'h99);
    check("dn_99_co", 32'(co_w), 32'd1);
    check("dn_99_tc", 32'(tc_w), 32'd0);
    step();
    check("dn_98", 32'(o_w), 32'h98);
    check("dn_98_co", 32'(co_w), 32'd0);

    // saturate at 99 going up
    Load = 1'b1; d2 = 8'h98; Up = 1'b1;
    step();
    check("sat_load", 32'(o_s), 32'h98);
    Load = 1'b0;
    step();
    check("sat_e1_o", 32'(o_s), 32'h99);
    check("sat_e1_co", 32'(co_s), 32'd0);
    check("sat_e1_tc", 32'(tc_s), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("sat_hold_o", 32'(o_s), 32'h99);
      check("sat_hold_co", 32'(co_s), 32'd1);
    end
    En = 1'b0;
    step();
    check("sat_idle_co", 32'(co_s), 32'd0);
    check("sat_idle_o", 32'(o_s), 32'h99);

    // saturate at 00 going down
    Load = 1'b1; d2 = 8'h00;
    step();
    Load = 1'b0; En = 1'b1; Up = 1'b0;
    step();
    check("sat_dn_o", 32'(o_s), 32'h00);
    check("sat_dn_co", 32'(co_s), 32'd1);
    step();
    check("sat_dn_co_rep", 32'(co_s), 32'd1);

    // hold, then asynchronous reset mid-count
    Load = 1'b1; d2 = 8'h42;
    step();
    Load = 1'b0; En = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_o", 32'(o_w), 32'h42);
      check("hold_co", 32'(co_w), 32'd0);
    end
    En = 1'b1; Up = 1'b1;
    step();
    check("resume_o", 32'(o_w), 32'h43);
    #2 R = 1'b1;
    #1;
    check("midrst_o", 32'(o_w), 32'h00);
    check("midrst_o_4", 32'(o_4), 32'h0000);
    #1 R = 1'b0;
    step();
    check("post_rst_o", 32'(o_w), 32'h01);

    // four-decade ripple
    Load = 1'b1; d4 = 16'h0999;
    step();
    Load = 1'b0; Up = 1'b1;
    step();
    check("rip_up_o_4", 32'(o_4), 32'h1000);
    check("rip_up_co_4", 32'(co_4), 32'd0);
    Load = 1'b1; d4 = 16'h1000;
    step();
    Load = 1'b0; Up = 1'b0;
    step();
    check("rip_dn_o_4", 32'(o_4), 32'h0999);
    check("rip_dn_co_4", 32'(co_4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_bcd_ndigit.md
Name: counter_bcd_ndigit

Overview:
- Parametrised multi-digit BCD counter that generalises the single-digit 0-9 counter.
- Adds:
  - DIGITS-wide cascaded decades
  - up/down counting
  - count enable
  - parallel load
  - wrap or saturate mode
  - terminal-count and carry/borrow outputs for cascading
- Drives seven-segment display paths and timer/stopwatch blocks in the lab designs.

Parameters:
- DIGITS, 2, number of BCD decades (1..8); digit 0 is least significant, at O[3:0].
- WRAP, 1, 1 = wrap at the boundaries (all-9s <-> 0); 0 = saturate at the boundary.

Ports:
- Clk  input  1  rising-edge clock.
- R  input  1  asynchronous active-high reset.
- En  input  1  count enable; one step per Clk edge while high.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load of D.
- D  input  4*DIGITS  BCD load value, digit i at D[4i+3:4i].
- O  output  4*DIGITS  current BCD count, digit i at O[4i+3:4i].
- Tc  output  1  combinational terminal count.
- Co  output  1  registered carry/borrow/overflow pulse.

Behaviour:
- Reset: R high forces O = 0 and Co = 0 immediately, independent of Clk. While R is high, all other inputs are ignored. Counting resumes on the first rising edge after R falls.
- Invariant: every digit of O is always in 0..9. No non-BCD value is ever stored.
- Priority per Clk edge: R > Load > En > hold.
- Load (Load = 1):
  - O <= D, with any digit of D greater than 9 clamped to 9 (per digit).
  - Co <= 0.
  - En and Up are ignored that cycle.
- Hold (En = 0, Load = 0): O unchanged; Co <= 0.
- Up count (En = 1, Up = 1):
  - Digit 0 steps +1 each edge.
  - Digit i steps when all digits below it are 9.
  - A stepping digit at 9 goes to 0; otherwise it goes to digit + 1.
- Down count (En = 1, Up = 0):
  - Digit 0 steps -1 each edge.
  - Digit i steps when all digits below it are 0.
  - A stepping digit at 0 goes to 9; otherwise it goes to digit - 1.
- Boundary, WRAP = 1:
  - Up from all-9s gives 0.
  - Down from 0 gives all-9s.
  - Co <= 1 for exactly the one cycle following that edge.
- Boundary, WRAP = 0:
  - Up at all-9s, or down at 0, holds O unchanged.
  - Co <= 1 for the following cycle (overflow/underflow indication).
  - Co repeats every cycle while the attempt persists.
- Co <= 0 on every other edge. Co latency is one cycle after the boundary edge.
- Tc is combinational from O and Up, and ignores En:
  - Tc = 1 when Up = 1 and O = all-9s.
  - Tc = 1 when Up = 0 and O = 0.
  - Cascading stages use En_next = En & Tc.
- Direction change mid-count: takes effect on the next edge; there is no pipeline state.
- Reset asserted mid-count or mid-load: the count is lost and O = 0; there is no pending state.

Test Plan:
- Reset/count-up (DIGITS = 2, WRAP = 1): pulse R between clock edges -> O = 0x00 and Co = 0 immediately. Then En = 1, Up = 1 for 100 edges -> O steps 00, 01, ..., 09, 10, ..., 99, 00. Co = 1 for exactly one cycle after the 99 -> 00 edge. Tc = 1 only while O = 99.
- Count-down wrap: load D = 0x01, then En = 1, Up = 0 -> O = 01, 00, 99, 98. Tc = 1 while O = 00. Co pulses once after the 00 -> 99 edge.
- Load priority and clamping: Load = 1, En = 1, D = 0xA7 -> O = 0x97, Co = 0, no count that cycle. Next edge with Load = 0, Up = 1 -> O = 0x98.
- Saturate (WRAP = 0): load 0x98, En = 1, Up = 1 for 4 edges -> O = 98, 99, 99, 99. Co = 0, 0, 1, 1 in the cycles following each edge. Down at 00 -> O stays 00 and Co = 1.
- Hold and asynchronous reset mid-count: En = 0 at O = 0x42 for 3 edges -> O stays 0x42, Co = 0. Then assert R asynchronously mid-cycle while En = 1 -> O = 0x00 before the next edge.
- DIGITS = 4 carry ripple: load 0x0999, one up edge -> O = 0x1000. Load 0x1000, one down edge -> O = 0x0999, Co = 0.
